math_round_ctrl: RTL
====================

# math_round_ctrl

Round controller for the math challenge game. It generates pseudo-random 4-bit problems for the add, subtract, multiply and divide units and presents each problem to the player interface. It then waits for an 8-bit answer with a timeout, checks the answer against the expected result and keeps a score over a fixed number of rounds. The block sits between the player I/O logic and the arithmetic datapath, and is the only sequencer in the game.

## Interface
- NUM_ROUNDS, 10: rounds per game; legal range 1..255.
- TIMEOUT_CYCLES, 1000: maximum cycles a question stays open; legal range 2..65535.
- LFSR_SEED, 12'h9C3: LFSR value loaded on reset; must be non-zero.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  pulse; begins a new game in IDLE or DONE, ignored elsewhere.
- answer_valid  in  1  player answer strobe.
- answer  in  8  player answer, unsigned.
- operand1  out  4  presented first operand.
- operand2  out  4  presented second operand.
- op_sel  out  2  operation: 0 ADD, 1 SUB, 2 MUL, 3 DIV.
- question_valid  out  1  question open; answer_valid is accepted only while this is high.
- result_valid  out  1  one-cycle pulse when a round completes.
- correct  out  1  qualifies result_valid; answer matched.
- timed_out  out  1  qualifies result_valid; round ended by timeout.
- score  out  8  correct answers in the current game.
- round_idx  out  8  zero-based index of the current round.
- busy  out  1  high in every state except IDLE and DONE.
- done  out  1  high in DONE.

## Operation
- States: IDLE, GEN, ASK, SHOW, DONE.
- IDLE, or DONE with start=1: clear score and round_idx, then go to GEN.
- GEN (1 cycle):
  - Take the fields from the current LFSR value: op_sel=lfsr[11:10], raw operand1=lfsr[7:4], raw operand2=lfsr[3:0].
  - Normalize: for SUB with operand1<operand2, swap the operands. For DIV with operand2==0, force operand2=1.
  - Register the operands, op_sel and the 8-bit expected result (sum, difference, product, or truncated quotient).
  - Advance the LFSR one step. Taps x^12+x^6+x^4+x+1, Fibonacci, shifting left. The LFSR advances only in GEN.
  - Go to ASK.
- ASK:
  - Timer starts at 0 on entry and increments every ASK cycle.
  - If answer_valid=1: correct=(answer==expected), and score increments if correct. Go to SHOW.
  - Else if timer==TIMEOUT_CYCLES-1: correct=0, timed_out=1. Go to SHOW.
  - If answer_valid and the timeout occur in the same cycle, the answer wins.
- SHOW (1 cycle): result_valid=1 with correct and timed_out.
  - If round_idx==NUM_ROUNDS-1, go to DONE.
  - Otherwise increment round_idx and go to GEN.
- DONE: done=1, and score and round_idx hold until start.
- Operands and op_sel hold their values from GEN until the next GEN. correct and timed_out hold until the next ASK exit.
- Score cannot overflow because NUM_ROUNDS ≤ 255.

## Timing
- Reset: state IDLE and LFSR=LFSR_SEED. Every output is 0, including operands, op_sel, score, round_idx, busy and done.
- Reset mid-game aborts immediately with no result_valid. The next game replays from the seed.
- start sampled at edge 0 → GEN after edge 1 → question_valid high after edge 2.
- answer_valid sampled at edge k during ASK → result_valid high for the cycle after edge k → question_valid high again after edge k+2.
- Timeout: question_valid stays high for exactly TIMEOUT_CYCLES cycles, then result_valid pulses.
- answer_valid outside ASK is ignored. start outside IDLE/DONE is ignored.

## Structure
- Package math_pkg:
  - op encodings OP_ADD, OP_SUB, OP_MUL, OP_DIV
  - round_state_t enum
  - LFSR_TAPS constant
- Sub-module lfsr12, with a step enable and a seed parameter, generates the problems.
- The expected-result mux stays inline in math_round_ctrl.

## Test plan
- Reset, then start → after 2 cycles question_valid=1, op_sel=2 (MUL), operand1=12, operand2=3. Answer 8'h24 → result_valid, correct=1, score=1.
- Same first question with answer 35 → correct=0, timed_out=0, score=0.
- TIMEOUT_CYCLES=8, no answer → question_valid high 8 cycles, then result_valid with timed_out=1. Answer on the 8th cycle → correct=1 and timed_out=0.
- Normalization:
  - LFSR_SEED=12'h435 → SUB presented as 5−3, expects 2.
  - LFSR_SEED=12'hC70 → DIV presented as 7/1, expects 7.
- NUM_ROUNDS=3, all answers correct → three result_valid pulses, then done=1 and score=3. A second start clears score to 0 and sets busy=1.
- Assert rst mid-ASK → all outputs 0 in the same cycle. The next start presents the seed question again (12×3).

Source files
------------

// File: rtl/math_pkg.sv
// Shared encodings for the math challenge round controller: operation codes,
// round sequencer states and the problem-generator LFSR feedback taps.
package math_pkg;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  // x^12 + x^6 + x^4 + x + 1, as a mask over bits 11, 5, 3 and 0
  localparam logic [11:0] LFSR_TAPS = 12'h829;

  typedef enum logic [2:0] {
    IDLE,
    GEN,
    ASK,
    SHOW,
    DONE
  } round_state_t;

endpackage

// File: rtl/lfsr12.sv
// 12-bit Fibonacci LFSR (shift left) that supplies the raw problem fields;
// it only moves when step is high so each question consumes exactly one state.
module lfsr12 import math_pkg::*; #(
  parameter logic [11:0] SEED = 12'h9C3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       step,
  output logic [1:0] field_op,
  output logic [3:0] field_a,
  output logic [3:0] field_b
);

  logic [11:0] value;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= SEED;
    end else if (step) begin
      value <= {value[10:0], ^(value & LFSR_TAPS)};
    end
  end

  assign field_op = value[11:10];
  assign field_a  = value[7:4];
  assign field_b  = value[3:0];

endmodule

// File: rtl/math_round_ctrl.sv
// Round sequencer for the math challenge game: generates a problem, holds it
// open for an answer or a timeout, scores the result and counts rounds.
module math_round_ctrl import math_pkg::*; #(
  parameter int          NUM_ROUNDS     = 10,
  parameter int          TIMEOUT_CYCLES = 1000,
  parameter logic [11:0] LFSR_SEED      = 12'h9C3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       answer_valid,
  input  logic [7:0] answer,
  output logic [3:0] operand1,
  output logic [3:0] operand2,
  output logic [1:0] op_sel,
  output logic       question_valid,
  output logic       result_valid,
  output logic       correct,
  output logic       timed_out,
  output logic [7:0] score,
  output logic [7:0] round_idx,
  output logic       busy,
  output logic       done
);

  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]  ROUND_LAST = 8'(NUM_ROUNDS - 1);

  round_state_t state, state_next;
  logic         start_q;
  logic         lfsr_step;
  logic [1:0]   raw_op;
  logic [3:0]   raw_a, raw_b;
  logic [3:0]   gen_a, gen_b;
  logic [7:0]   gen_result;
  logic [7:0]   expected;
  logic [15:0]  timer;
  logic         timeout_hit;

  assign lfsr_step = (state == GEN);

  lfsr12 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .step     (lfsr_step),
    .field_op (raw_op),
    .field_a  (raw_a),
    .field_b  (raw_b)
  );

  // Keep subtraction non-negative and division defined before computing the answer
  always_comb begin
    gen_a = raw_a;
    gen_b = raw_b;
    if (raw_op == OP_SUB && raw_a < raw_b) begin
      gen_a = raw_b;
      gen_b = raw_a;
    end
    if (raw_op == OP_DIV && raw_b == 4'd0) begin
      gen_b = 4'd1;
    end
    case (raw_op)
      OP_ADD:  gen_result = {4'd0, gen_a} + {4'd0, gen_b};
      OP_SUB:  gen_result = {4'd0, gen_a} - {4'd0, gen_b};
      OP_MUL:  gen_result = {4'd0, gen_a} * {4'd0, gen_b};
      default: gen_result = {4'd0, gen_a / gen_b};
    endcase
  end

  assign timeout_hit = (timer == TIMER_LAST);

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: if (start_q) state_next = GEN;
      GEN:        state_next = ASK;
      ASK:        if (answer_valid || timeout_hit) state_next = SHOW;
      SHOW:       state_next = (round_idx == ROUND_LAST) ? DONE : GEN;
      default:    state_next = IDLE;
    endcase
  end

  // start is registered, so a new game reaches GEN one cycle after it is sampled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      start_q   <= 1'b0;
      operand1  <= 4'd0;
      operand2  <= 4'd0;
      op_sel    <= 2'd0;
      expected  <= 8'd0;
      timer     <= 16'd0;
      correct   <= 1'b0;
      timed_out <= 1'b0;
      score     <= 8'd0;
      round_idx <= 8'd0;
    end else begin
      state   <= state_next;
      start_q <= start && (state == IDLE || state == DONE);
      case (state)
        IDLE, DONE: begin
          if (start_q) begin
            score     <= 8'd0;
            round_idx <= 8'd0;
          end
        end
        GEN: begin
          operand1 <= gen_a;
          operand2 <= gen_b;
          op_sel   <= raw_op;
          expected <= gen_result;
          timer    <= 16'd0;
        end
        ASK: begin
          timer <= timer + 16'd1;
          if (answer_valid) begin
            correct   <= (answer == expected);
            timed_out <= 1'b0;
            if (answer == expected) score <= score + 8'd1;
          end else if (timeout_hit) begin
            correct   <= 1'b0;
            timed_out <= 1'b1;
          end
        end
        SHOW: begin
          if (round_idx != ROUND_LAST) round_idx <= round_idx + 8'd1;
        end
        default: ;
      endcase
    end
  end

  assign question_valid = (state == ASK);
  assign result_valid   = (state == SHOW);
  assign busy           = (state != IDLE) && (state != DONE);
  assign done           = (state == DONE);

endmodule
